// File: rtl/sum_sram_rmw_arbiter.sv
// sum_sram_rmw_arbiter
//   Shares one accumulation SRAM bank among NUM_REQ lanes. Each granted
//   request runs a non-overlapped read-modify-write, new = sat(mem[addr] + inc).
//   An i_clear command sweeps zeros over words 0..DEPTH-1.
//
// Ports
//   clk           system clock (also clocks the SRAM)
//   i_rst         asynchronous, active-high reset
//   i_req_valid   per-lane request, held until o_req_ack
//   i_req_addr    lane k address at [k*ADDR_WIDTH +: ADDR_WIDTH]
//   i_req_data    lane k increment at [k*DATA_WIDTH +: DATA_WIDTH]
//   o_req_ack     one-cycle grant pulse per lane
//   i_clear       pulse: zero the whole bank
//   o_busy        operation in progress or clear pending
//   o_sat         one-cycle pulse alongside a saturated write
//   o_sram_addr   SRAM address
//   o_sram_write  SRAM write enable
//   o_sram_wdata  SRAM write data
//   i_sram_rdata  SRAM read data, valid one cycle after the read edge
//
// state | meaning
// IDLE  | arbitrate: clear has priority, otherwise round-robin grant
// RD    | SRAM samples the read address at the end of this cycle
// CAP   | read data valid; compute saturated sum, present write
// WR    | write lands at the end of this cycle
// CLR   | one zero-write per cycle, address 0..DEPTH-1

module sum_sram_rmw_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = 7,
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 128
) (
   input  logic                             clk,
   input  logic                             i_rst,
   input  logic [NUM_REQ-1:0]               i_req_valid,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]    i_req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]    i_req_data,
   output logic [NUM_REQ-1:0]               o_req_ack,
   input  logic                             i_clear,
   output logic                             o_busy,
   output logic                             o_sat,
   output logic [ADDR_WIDTH-1:0]            o_sram_addr,
   output logic                             o_sram_write,
   output logic [DATA_WIDTH-1:0]            o_sram_wdata,
   input  logic [DATA_WIDTH-1:0]            i_sram_rdata
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD,
      ST_CAP,
      ST_WR,
      ST_CLR
   } state_t;

   state_t                state_q;
   logic [PTR_W-1:0]      ptr_q;
   logic [PTR_W-1:0]      ptr_d;
   logic [DATA_WIDTH-1:0] inc_q;
   logic                  clr_pend_q;

   logic                  win_found;
   logic [PTR_W-1:0]      win_idx;
   logic [PTR_W-1:0]      cand_idx;
   int                    cand;
   logic [ADDR_WIDTH-1:0] win_addr;
   logic [DATA_WIDTH-1:0] win_data;
   logic [DATA_WIDTH:0]   sum;

   // Round-robin search: first valid lane at or after ptr_q, wrapping.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = 0;
      cand_idx  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = int'(ptr_q) + k;
         if (cand >= NUM_REQ) begin
            cand = cand - NUM_REQ;
         end
         cand_idx = cand[PTR_W-1:0];
         if (!win_found && i_req_valid[cand_idx]) begin
            win_found = 1'b1;
            win_idx   = cand_idx;
         end
      end
   end

   assign win_addr = i_req_addr[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
   assign win_data = i_req_data[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
   assign ptr_d    = (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + 1'b1;

   // Extra carry bit detects overflow of the accumulate.
   assign sum = {1'b0, i_sram_rdata} + {1'b0, inc_q};

   assign o_busy = (state_q != ST_IDLE) | clr_pend_q;

   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
         state_q      <= ST_IDLE;
         ptr_q        <= '0;
         inc_q        <= '0;
         clr_pend_q   <= 1'b0;
         o_req_ack    <= '0;
         o_sat        <= 1'b0;
         o_sram_addr  <= '0;
         o_sram_write <= 1'b0;
         o_sram_wdata <= '0;
      end else begin
         o_req_ack <= '0;
         o_sat     <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (clr_pend_q || i_clear) begin
                  o_sram_addr  <= '0;
                  o_sram_write <= 1'b1;
                  o_sram_wdata <= '0;
                  state_q      <= ST_CLR;
               end else if (win_found) begin
                  o_req_ack[win_idx] <= 1'b1;
                  inc_q              <= win_data;
                  o_sram_addr        <= win_addr;
                  o_sram_write       <= 1'b0;
                  ptr_q              <= ptr_d;
                  state_q            <= ST_RD;
               end
            end
            ST_RD: begin
               if (i_clear) clr_pend_q <= 1'b1;
               state_q <= ST_CAP;
            end
            ST_CAP: begin
               if (i_clear) clr_pend_q <= 1'b1;
               o_sram_wdata <= sum[DATA_WIDTH] ? '1 : sum[DATA_WIDTH-1:0];
               o_sram_write <= 1'b1;
               o_sat        <= sum[DATA_WIDTH];
               state_q      <= ST_WR;
            end
            ST_WR: begin
               if (i_clear) clr_pend_q <= 1'b1;
               o_sram_write <= 1'b0;
               state_q      <= ST_IDLE;
            end
            ST_CLR: begin
               // i_clear is deliberately ignored here: a running sweep never restarts.
               if (o_sram_addr == LAST_ADDR) begin
                  o_sram_write <= 1'b0;
                  clr_pend_q   <= 1'b0;
                  state_q      <= ST_IDLE;
               end else begin
                  o_sram_addr <= o_sram_addr + 1'b1;
               end
            end
            default: begin
               o_sram_write <= 1'b0;
               state_q      <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sum_sram_rmw_arbiter.sv
`timescale 1ns/1ps
module tb_sum_sram_rmw_arbiter;

   localparam int NR    = 4;
   localparam int AW    = 7;
   localparam int DW    = 8;
   localparam int DEPTH = 128;

   logic               clk = 1'b0;
   logic               i_rst;
   logic [NR-1:0]      i_req_valid;
   logic [NR*AW-1:0]   i_req_addr;
   logic [NR*DW-1:0]   i_req_data;
   logic [NR-1:0]      o_req_ack;
   logic               i_clear;
   logic               o_busy;
   logic               o_sat;
   logic [AW-1:0]      o_sram_addr;
   logic               o_sram_write;
   logic [DW-1:0]      o_sram_wdata;
   logic [DW-1:0]      sram_rdata;

   sum_sram_rmw_arbiter #(
      .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)
   ) dut (
      .clk          (clk),
      .i_rst        (i_rst),
      .i_req_valid  (i_req_valid),
      .i_req_addr   (i_req_addr),
      .i_req_data   (i_req_data),
      .o_req_ack    (o_req_ack),
      .i_clear      (i_clear),
      .o_busy       (o_busy),
      .o_sat        (o_sat),
      .o_sram_addr  (o_sram_addr),
      .o_sram_write (o_sram_write),
      .o_sram_wdata (o_sram_wdata),
      .i_sram_rdata (sram_rdata)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic          sat;
   } wr_t;

   wr_t          wr_q[$];
   int           ack_q[$];
   int           ack_hist[$];
   logic [DW-1:0] sram_mem [DEPTH];
   logic [DW-1:0] exp_mem  [DEPTH];
   int           n_vec = 0;
   int           n_err = 0;
   int           cyc = 0;
   int           lane_total [NR];
   int           lane_acked [NR];
   logic [AW-1:0] lane_addr [NR];
   logic [DW-1:0] lane_inc  [NR];
   int           drive_cyc = 0;
   int           ack_cyc = 0;
   int           wr_cyc = 0;
   logic         sram_seed;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
      end
   endtask

   // SRAM model: synchronous write, registered read.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (sram_seed) begin
         for (int i = 0; i < DEPTH; i++) sram_mem[i] <= 8'($urandom);
      end else if (o_sram_write) begin
         sram_mem[o_sram_addr] <= o_sram_wdata;
      end
      sram_rdata <= sram_mem[o_sram_addr];
   end

   // Output monitor / scoreboard pop, then lane drivers (valid held until ack).
   always @(negedge clk) begin
      if (o_req_ack != '0) begin
         ack_cyc = cyc;
         ack_hist.push_back(cyc);
         if (ack_q.size() == 0) begin
            check_eq("unexpected_ack", 32'(o_req_ack), 32'd0);
         end else begin
            int l;
            l = ack_q.pop_front();
            check_eq("ack_lane", 32'(o_req_ack), 32'd1 << l);
         end
         for (int k = 0; k < NR; k++) if (o_req_ack[k]) lane_acked[k]++;
      end
      if (o_sram_write) begin
         wr_cyc = cyc;
         if (wr_q.size() == 0) begin
            check_eq("unexpected_write", 32'({o_sram_addr, o_sram_wdata, o_sat}), 32'd0);
         end else begin
            wr_t e;
            e = wr_q.pop_front();
            check_eq("write_addr_data_sat", 32'({o_sram_addr, o_sram_wdata, o_sat}), 32'(e));
         end
      end else if (o_sat) begin
         check_eq("stray_sat", 32'(o_sat), 32'd0);
      end
      for (int k = 0; k < NR; k++) begin
         logic v;
         v = (lane_total[k] != lane_acked[k]);
         if (v && i_req_valid[k] !== 1'b1) drive_cyc = cyc;
         i_req_valid[k]          = v;
         i_req_addr[k*AW +: AW]  = lane_addr[k];
         i_req_data[k*DW +: DW]  = lane_inc[k];
      end
   end

   task automatic push_acc(input int lane, input logic [AW-1:0] a, input logic [DW-1:0] inc);
      logic [DW:0]   s;
      logic [DW-1:0] d;
      s = {1'b0, exp_mem[a]} + {1'b0, inc};
      d = s[DW] ? {DW{1'b1}} : s[DW-1:0];
      exp_mem[a] = d;
      ack_q.push_back(lane);
      wr_q.push_back({a, d, s[DW]});
   endtask

   task automatic push_clear(input int n);
      for (int i = 0; i < n; i++) begin
         wr_q.push_back({AW'(i), DW'(0), 1'b0});
         exp_mem[i] = '0;
      end
   endtask

   task automatic lane_go(input int k, input logic [AW-1:0] a, input logic [DW-1:0] inc, input int cnt);
      lane_addr[k]  = a;
      lane_inc[k]   = inc;
      lane_total[k] = lane_total[k] + cnt;
   endtask

   function automatic bit lanes_done();
      bit d;
      d = 1'b1;
      for (int k = 0; k < NR; k++) if (lane_total[k] != lane_acked[k]) d = 1'b0;
      return d;
   endfunction

   task automatic wait_idle(input string tag);
      int n;
      bit done;
      n = 0;
      done = 1'b0;
      while (!done && n < 2000) begin
         @(posedge clk);
         #2;
         n++;
         done = lanes_done() && !o_busy;
      end
      check_eq({tag, "_completes"}, 32'(done), 32'd1);
   endtask

   task automatic pulse_clear();
      @(posedge clk); #1 i_clear = 1'b1;
      @(posedge clk); #1 i_clear = 1'b0;
   endtask

   task automatic check_outs_zero(input string tag);
      check_eq(tag, 32'({o_req_ack, o_busy, o_sat, o_sram_addr, o_sram_write, o_sram_wdata}), 32'd0);
   endtask

   task automatic reset_dut();
      @(posedge clk); #1 i_rst = 1'b1;
      #1 check_outs_zero("reset_outputs");
      @(posedge clk); #1 i_rst = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      bit found;
      int bad;
      i_rst = 1'b1;
      i_clear = 1'b0;
      sram_seed = 1'b1;
      for (int k = 0; k < NR; k++) begin
         lane_total[k] = 0;
         lane_addr[k]  = '0;
         lane_inc[k]   = '0;
      end
      for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
      repeat (2) @(posedge clk);
      #1 check_outs_zero("reset_outputs");
      sram_seed = 1'b0;
      i_rst = 1'b0;

      // Clear from IDLE zeroes the random bank.
      push_clear(DEPTH);
      pulse_clear();
      wait_idle("t0_clear");

      // Single request: ack one cycle after valid, write two cycles after ack.
      @(posedge clk); #1;
      push_acc(0, 7'd5, 8'd3);
      lane_go(0, 7'd5, 8'd3, 1);
      wait_idle("t1");
      check_eq("t1_ack_latency", 32'(ack_cyc - drive_cyc), 32'd1);
      check_eq("t1_write_latency", 32'(wr_cyc - ack_cyc), 32'd2);
      check_eq("t1_mem5", 32'(sram_mem[5]), 32'd3);

      // All lanes held: strict 0,1,2,3 rotation, one grant per 4 cycles.
      reset_dut();
      @(posedge clk); #1;
      for (int r = 0; r < 2; r++)
         for (int k = 0; k < NR; k++) push_acc(k, AW'(k), 8'd1);
      for (int k = 0; k < NR; k++) lane_go(k, AW'(k), 8'd1, 2);
      wait_idle("t2");
      n = ack_hist.size();
      check_eq("t2_grant_spacing", 32'(ack_hist[n-1] - ack_hist[n-8]), 32'd28);
      for (int k = 0; k < NR; k++) check_eq("t2_mem_k", 32'(sram_mem[k]), 32'd2);

      // Saturation boundary.
      @(posedge clk); #1;
      push_acc(1, 7'd9, 8'd250); lane_go(1, 7'd9, 8'd250, 1); wait_idle("t3a");
      @(posedge clk); #1;
      push_acc(1, 7'd9, 8'd10);  lane_go(1, 7'd9, 8'd10, 1);  wait_idle("t3b");
      @(posedge clk); #1;
      push_acc(1, 7'd9, 8'd0);   lane_go(1, 7'd9, 8'd0, 1);   wait_idle("t3c");
      check_eq("t3_mem9", 32'(sram_mem[9]), 32'd255);

      // Clear arriving during CAP: RMW finishes, sweep follows, then the next grant.
      reset_dut();
      @(posedge clk); #1;
      push_acc(2, 7'd20, 8'h11);
      lane_go(2, 7'd20, 8'h11, 1);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if (o_req_ack[2]) found = 1'b1;
      end
      check_eq("t4_ack2_seen", 32'(found), 32'd1);
      @(posedge clk); #1 i_clear = 1'b1;
      push_clear(DEPTH);
      push_acc(0, 7'd21, 8'd5);
      lane_go(0, 7'd21, 8'd5, 1);
      @(posedge clk); #1 i_clear = 1'b0;
      n = 0;
      while (n < 400) begin
         @(negedge clk);
         n++;
         if (!o_busy) break;
      end
      check_eq("t4_busy_cycles", 32'(n), 32'd131);
      wait_idle("t4");
      check_eq("t4_mem20", 32'(sram_mem[20]), 32'd0);
      check_eq("t4_mem21", 32'(sram_mem[21]), 32'd5);

      // Two lanes hitting the same address: no lost update.
      reset_dut();
      @(posedge clk); #1;
      push_acc(1, 7'd7, 8'd4);
      push_acc(3, 7'd7, 8'd4);
      lane_go(1, 7'd7, 8'd4, 1);
      lane_go(3, 7'd7, 8'd4, 1);
      wait_idle("t5");
      check_eq("t5_mem7", 32'(sram_mem[7]), 32'd8);

      // Reset in the middle of a sweep.
      @(posedge clk); #1;
      push_acc(0, 7'd40, 8'h5A);  lane_go(0, 7'd40, 8'h5A, 1);  wait_idle("t6a");
      @(posedge clk); #1;
      push_acc(1, 7'd77, 8'hC3);  lane_go(1, 7'd77, 8'hC3, 1);  wait_idle("t6b");
      @(posedge clk); #1;
      push_acc(2, 7'd127, 8'h0F); lane_go(2, 7'd127, 8'h0F, 1); wait_idle("t6c");
      push_clear(40);
      pulse_clear();
      found = 1'b0;
      for (int i = 0; i < 300 && !found; i++) begin
         @(negedge clk);
         if (o_sram_write && o_sram_addr == 7'd39) found = 1'b1;
      end
      check_eq("t6_reached_addr39", 32'(found), 32'd1);
      @(posedge clk); #1 i_rst = 1'b1;
      #1 check_outs_zero("t6_reset_mid_clear");
      @(posedge clk);
      @(posedge clk); #1 i_rst = 1'b0;
      repeat (5) @(posedge clk);
      #1 check_eq("t6_no_resume", 32'({o_busy, o_sram_write}), 32'd0);
      bad = 0;
      for (int i = 0; i < DEPTH; i++) if (sram_mem[i] !== exp_mem[i]) bad++;
      check_eq("t6_bank_contents", 32'(bad), 32'd0);
      check_eq("t6_mem40", 32'(sram_mem[40]), 32'h5A);
      check_eq("t6_mem77", 32'(sram_mem[77]), 32'hC3);
      check_eq("t6_mem127", 32'(sram_mem[127]), 32'h0F);

      check_eq("pending_writes", 32'(wr_q.size()), 32'd0);
      check_eq("pending_acks", 32'(ack_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
